muldiv_unit: RTL and testbench

//   Iterative RV32M multiply/divide unit. Takes rs1/rs2 operand values read from the register

---
 rtl/muldiv_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit. It accepts operand values read from the
//   register file and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU in 32
//   iterations. The result is driven onto the register-file write port. The core
//   stalls while busy is high.
//
//   Multiply uses shift-add on operand magnitudes and produces a 64-bit product.
//   Divide uses restoring division on magnitudes and produces a quotient and a
//   remainder. Both share one 64-bit accumulator. The sign is applied in FIX.
//   Divide-by-zero and signed overflow take a one-cycle fast path.
//
// Ports
//   clk          in   1           clock, rising edge
//   areset       in   1           asynchronous reset, active-low
//   start        in   1           request, sampled only in IDLE
//   flush        in   1           abort in-flight op, no write-back
//   funct3       in   3           RV32M operation select
//   rs1_val      in   XLEN        operand A / dividend
//   rs2_val      in   XLEN        operand B / divisor
//   rd           in   REG_ADDR_W  destination register index
//   busy         out  1           high in CALC, FIX, DONE
//   done         out  1           one-cycle pulse, result valid
//   writeEnable  out  1           RF write strobe (done and rd != 0)
//   writeReg     out  REG_ADDR_W  RF write index (latched rd)
//   writeData    out  XLEN        result, held until the next done
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  start,
  input  logic                  flush,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       rs1_val,
  input  logic [XLEN-1:0]       rs2_val,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  busy,
  output logic                  done,
  output logic                  writeEnable,
  output logic [REG_ADDR_W-1:0] writeReg,
  output logic [XLEN-1:0]       writeData
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state;
  logic [5:0]          count;
  logic [2:0]          op;        // latched funct3
  logic                a_neg;     // operand A was negative (signed view)
  logic                b_neg;     // operand B was negative (signed view)
  logic [XLEN-1:0]     opb;       // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc;       // {hi, lo}: product, or {remainder, quotient}
  logic                done_q;
  logic                we_q;

  // Decode on the accept cycle.
  logic                a_signed;
  logic                b_signed;
  logic                a_neg_in;
  logic                b_neg_in;
  logic [XLEN-1:0]     a_mag;
  logic [XLEN-1:0]     b_mag;
  logic                div_zero;
  logic                div_ovf;
  logic [XLEN-1:0]     special_val;

  // One iteration of the datapath.
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift;
  logic [XLEN:0]       div_diff;
  logic                div_take;
  logic [2*XLEN-1:0]   acc_next;

  // Sign fix-up and result select.
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quot_fix;
  logic [XLEN-1:0]     rem_fix;
  logic [XLEN-1:0]     result;

  // NOTE: every always_comb output gets a default before any branch. A path that
  // leaves a signal unassigned would infer a latch.
  always_comb begin
    a_signed    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg_in    = a_signed && rs1_val[XLEN-1];
    b_neg_in    = b_signed && rs2_val[XLEN-1];
    // The magnitude of MIN_INT is 2^(XLEN-1). That value is exact as unsigned.
    a_mag       = a_neg_in ? -rs1_val : rs1_val;
    b_mag       = b_neg_in ? -rs2_val : rs2_val;
    div_zero    = funct3[2] && (rs2_val == '0);
    div_ovf     = funct3[2] && !funct3[0] && (rs1_val == MIN_INT) && (rs2_val == '1);
    special_val = '0;
    if (div_zero)
      special_val = funct3[1] ? rs1_val : '1;
    else if (div_ovf)
      special_val = funct3[1] ? '0 : MIN_INT;
  end

  always_comb begin
    // Multiply: add the multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    // Restoring divide: shift the next dividend bit into the remainder. Keep the
    // difference only when it does not go negative.
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb};
    div_take  = !div_diff[XLEN];
    if (op[2])
      acc_next = {(div_take ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                  acc[XLEN-2:0], div_take};
    else
      acc_next = {mul_sum, acc[XLEN-1:1]};
  end

  always_comb begin
    prod_fix = (a_neg ^ b_neg) ? -acc : acc;
    quot_fix = (a_neg ^ b_neg) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = a_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (op[2])
      result = op[1] ? rem_fix : quot_fix;
    else if (op[1:0] == 2'b00)
      result = prod_fix[XLEN-1:0];
    else
      result = prod_fix[2*XLEN-1:XLEN];
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then updates from values that were present before the edge.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state     <= S_IDLE;
      count     <= '0;
      busy      <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
      // NOTE: the datapath registers are reset too. Nothing from an aborted
      // operation can then leak into the next result.
      op        <= '0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      opb       <= '0;
      acc       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          we_q   <= 1'b0;
          if (start && !flush) begin
            op       <= funct3;
            writeReg <= rd;
            a_neg    <= a_neg_in;
            b_neg    <= b_neg_in;
            count    <= '0;
            busy     <= 1'b1;
            if (div_zero || div_ovf) begin
              writeData <= special_val;
              done_q    <= 1'b1;
              we_q      <= (rd != '0);
              state     <= S_DONE;
            end else begin
              acc   <= funct3[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
              opb   <= funct3[2] ? b_mag : a_mag;
              state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            acc <= acc_next;
            if (count == 6'd31) begin
              count <= '0;
              state <= S_FIX;
            end else begin
              count <= count + 6'd1;
            end
          end
        end

        S_FIX: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            writeData <= result;
            done_q    <= 1'b1;
            we_q      <= (writeReg != '0);
            state     <= S_DONE;
          end
        end

        S_DONE: begin
          done_q <= 1'b0;
          we_q   <= 1'b0;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // A flush in the DONE cycle suppresses the pulse and the write-back.
  assign done        = done_q && !flush;
  assign writeEnable = we_q && !flush;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit. Each operation pushes its expected
//   write-back (data, register, enable, latency) onto a scoreboard queue. The
//   entry is popped and compared when done is observed. Outputs are sampled on
//   the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        areset;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic        writeEnable;
  logic [4:0]  writeReg;
  logic [31:0] writeData;

  muldiv_unit dut (
    .clk         (clk),
    .areset      (areset),
    .start       (start),
    .flush       (flush),
    .funct3      (funct3),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .rd          (rd),
    .busy        (busy),
    .done        (done),
    .writeEnable (writeEnable),
    .writeReg    (writeReg),
    .writeData   (writeData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  wreg;
    logic        we;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Reference model built from the language's own 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int          ia = a;
    int          ib = b;
    longint      sa = ia;
    longint      sb_ = ib;
    longint      ua = longint'({32'b0, a});
    longint      ub = longint'({32'b0, b});
    logic [63:0] p;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'b001: begin p = sa * sb_; return p[63:32]; end
      3'b010: begin p = sa * ub;  return p[63:32]; end
      3'b011: begin p = ua * ub;  return p[63:32]; end
      3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issues one operation and waits for its write-back. When lat reaches
  // disturb, start is pulsed while the unit is busy, carrying a different
  // operation.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input logic [31:0] exp_data, input int disturb);
    exp_t e;
    exp_t g;
    int   lat;
    e.data = exp_data;
    e.wreg = r;
    e.we   = (r != 5'd0);
    e.lat  = is_special(f3, a, b) ? 1 : 34;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b; rd = r;
    @(negedge clk);
    start = 1'b0; funct3 = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom; rd = 5'($urandom);
    check({tag, "/busy"}, 64'(busy), 64'd1);
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == disturb) begin
        start = 1'b1; funct3 = 3'b101; rs1_val = 32'd1000; rs2_val = 32'd3; rd = 5'd30;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    g = sb.pop_front();
    if (done) begin
      check({tag, "/data"}, 64'(writeData), 64'(g.data));
      check({tag, "/reg"}, 64'(writeReg), 64'(g.wreg));
      check({tag, "/we"}, 64'(writeEnable), 64'(g.we));
      check({tag, "/latency"}, 64'(lat), 64'(g.lat));
      last_data = g.data;
      @(negedge clk);
      check({tag, "/pulse"}, 64'({done, busy}), 64'd0);
    end else begin
      check({tag, "/timeout"}, 64'd0, 64'd1);
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    int          saw_done;

    areset = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = '0; rs1_val = '0; rs2_val = '0; rd = '0;
    repeat (2) @(negedge clk);
    check("reset/busy", 64'(busy), 64'd0);
    check("reset/done", 64'(done), 64'd0);
    check("reset/we", 64'(writeEnable), 64'd0);
    check("reset/reg", 64'(writeReg), 64'd0);
    check("reset/data", 64'(writeData), 64'd0);
    areset = 1'b1;

    // Directed vectors with hand-derived results.
    run_op("mul",     3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 0);
    run_op("mulh",    3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 0);
    run_op("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 0);
    run_op("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'd2,          5'd8, 32'hFFFF_FFFF, 0);
    run_op("div",     3'b100, 32'hFFFF_FFF9, 32'd2,          5'd9, 32'hFFFF_FFFD, 0);
    run_op("rem",     3'b110, 32'hFFFF_FFF9, 32'd2,          5'd10, 32'hFFFF_FFFF, 0);
    run_op("divu",    3'b101, 32'd100,        32'd7,          5'd11, 32'd14, 0);
    run_op("remu",    3'b111, 32'd100,        32'd7,          5'd12, 32'd2, 0);
    run_op("div0",    3'b100, 32'd1234,       32'd0,          5'd13, 32'hFFFF_FFFF, 0);
    run_op("remu0",   3'b111, 32'd9,          32'd0,          5'd14, 32'd9, 0);
    run_op("divovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0);
    run_op("removf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 0);
    run_op("rd0",     3'b000, 32'd6,          32'd7,          5'd0, 32'd42, 0);
    run_op("busystart", 3'b000, 32'd3,        32'd5,          5'd17, 32'd15, 5);

    // Randomised operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      f3 = 3'(i % 8);
      a  = $urandom;
      b  = (i % 7 == 3) ? 32'd0 : (i % 5 == 1) ? 32'($urandom_range(1, 9)) : $urandom;
      if (i % 6 == 2) a = -a;
      run_op("rand", f3, a, b, 5'($urandom_range(0, 31)), model(f3, a, b), 0);
    end

    // Flush at CALC iteration 10: back to IDLE, no done, result unchanged.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rs1_val = 32'd11; rs2_val = 32'd13; rd = 5'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    check("flush/done_cycle", 64'(done), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    check("flush/busy", 64'(busy), 64'd0);
    check("flush/data", 64'(writeData), 64'(last_data));
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    check("flush/no_done", 64'(saw_done), 64'd0);

    // flush together with start in IDLE: nothing accepted.
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; rs1_val = 32'd2; rs2_val = 32'd2; rd = 5'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flushstart/busy", 64'(busy), 64'd0);
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    check("flushstart/no_done", 64'(saw_done), 64'd0);

    // Asynchronous reset at CALC iteration 20.
    start = 1'b1; funct3 = 3'b000; rs1_val = 32'h1234_5678; rs2_val = 32'h9ABC_DEF0; rd = 5'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    areset = 1'b0;
    #1;
    check("areset/busy", 64'(busy), 64'd0);
    check("areset/done", 64'(done), 64'd0);
    check("areset/we", 64'(writeEnable), 64'd0);
    check("areset/data", 64'(writeData), 64'd0);
    @(negedge clk);
    areset = 1'b1;
    run_op("postreset", 3'b000, 32'd3, 32'd4, 5'd4, 32'd12, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
